multi_channel_bin2ascii: RTL and testbench

- Parametrised successor to the per-axis binary-to-ASCII conversion stage of the accelerometer display path.
- One shared, time-multiplexed double-dabble engine converts NUM_CH signed or unsigned binary channels to fixed-width ASCII decimal.
- Converts every channel from an atomic snapshot and commits all results together.
- Adds overflow saturation and optional leading-zero blanking, and replaces N parallel converters with one engine.

---
 rtl/bin2ascii_pkg.sv | 25 ++
 rtl/dd_shift_core.sv | 71 +++++++
 rtl/multi_channel_bin2ascii.sv | 183 ++++++++++++++++++
 tb/tb_multi_channel_bin2ascii.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2ascii_pkg.sv
// Shared definitions for the multi-channel binary-to-ASCII converter:
// FSM state encoding, ASCII character constants and the double-dabble
// add-3 nibble correction.
package bin2ascii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_DONE
    } state_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Double-dabble pre-shift correction: a digit >= 5 would become >= 10
    // after doubling, so bias it by 3 so that the shift carries into the next
    // digit.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/dd_shift_core.sv
// Double-dabble shift engine: a (BCD_DIGITS+1)-digit BCD register
// concatenated with a BIN_WIDTH-bit magnitude register.
//   clk, reset  : clock, asynchronous active-low reset
//   enable      : clock-enable, low holds all state
//   load_i      : clear BCD/carry and load mag_i
//   step_i      : one add-3 + shift-left iteration
//   mag_i       : unsigned magnitude to convert
//   bcd_o       : BCD result, extra (overflow) digit in the top nibble
//   carry_o     : sticky flag, a bit was shifted out of the BCD register
module dd_shift_core
    import bin2ascii_pkg::*;
#(
    parameter int BIN_WIDTH  = 12,
    parameter int BCD_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        load_i,
    input  logic                        step_i,
    input  logic [BIN_WIDTH-1:0]        mag_i,
    output logic [(BCD_DIGITS+1)*4-1:0] bcd_o,
    output logic                        carry_o
);

    localparam int BCD_W = (BCD_DIGITS + 1) * 4;

    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [BIN_WIDTH-1:0] mag_q, mag_d;
    logic                 carry_q, carry_d;

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = '0;
        for (int d = 0; d < BCD_DIGITS + 1; d++) begin
            bcd_adj[d*4 +: 4] = add3(bcd_q[d*4 +: 4]);
        end

        bcd_d   = bcd_q;
        mag_d   = mag_q;
        carry_d = carry_q;
        if (load_i) begin
            bcd_d   = '0;
            mag_d   = mag_i;
            carry_d = 1'b0;
        end else if (step_i) begin
            bcd_d   = {bcd_adj[BCD_W-2:0], mag_q[BIN_WIDTH-1]};
            mag_d   = {mag_q[BIN_WIDTH-2:0], 1'b0};
            carry_d = carry_q | bcd_adj[BCD_W-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q   <= '0;
            mag_q   <= '0;
            carry_q <= 1'b0;
        end else if (enable) begin
            bcd_q   <= bcd_d;
            mag_q   <= mag_d;
            carry_q <= carry_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/multi_channel_bin2ascii.sv
// Converts NUM_CH binary channels (signed or unsigned) to fixed-width ASCII
// decimal with one time-multiplexed double-dabble engine. All channels are
// converted from a snapshot taken at start and committed together.
//   clk, reset   : clock, asynchronous active-low reset
//   enable       : clock-enable, low freezes everything
//   start        : conversion request, honoured in IDLE only
//   bin_flat     : channel k at [k*BIN_WIDTH +: BIN_WIDTH]
//   ascii_flat   : channel k at [k*BCD_DIGITS*8 +: BCD_DIGITS*8], MS digit on top
//   is_negative  : per-channel sign of the committed result
//   overflow     : per-channel magnitude >= 10^BCD_DIGITS (digits read all '9')
//   busy         : conversion in progress
//   done         : one-cycle pulse when results commit
module multi_channel_bin2ascii
    import bin2ascii_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int BIN_WIDTH  = 12,
    parameter int BCD_DIGITS = 4,
    parameter bit SIGNED     = 1'b1,
    parameter bit BLANK_LZ   = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           start,
    input  logic [NUM_CH*BIN_WIDTH-1:0]    bin_flat,
    output logic [NUM_CH*BCD_DIGITS*8-1:0] ascii_flat,
    output logic [NUM_CH-1:0]              is_negative,
    output logic [NUM_CH-1:0]              overflow,
    output logic                           busy,
    output logic                           done
);

    localparam int CH_W  = BCD_DIGITS * 8;
    localparam int ALL_W = NUM_CH * CH_W;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int BCD_W = (BCD_DIGITS + 1) * 4;

    localparam logic [IDX_W-1:0] LAST_CH    = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(BIN_WIDTH);
    localparam logic [ALL_W-1:0] ASCII_INIT = {(NUM_CH*BCD_DIGITS){ASCII_ZERO}};

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            ch_idx_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [NUM_CH*BIN_WIDTH-1:0] snap_q;
    logic [ALL_W-1:0]            shadow_ascii_q, ascii_q;
    logic [NUM_CH-1:0]           shadow_neg_q, shadow_ovf_q, neg_q, ovf_q;
    logic                        done_q;

    // Channel select and sign/magnitude split. Negating the most negative
    // code wraps to 2^(BIN_WIDTH-1), which is the correct magnitude.
    logic [BIN_WIDTH-1:0] raw_sel, mag_sel;
    logic                 neg_sel;

    always_comb begin
        raw_sel = snap_q[ch_idx_q*BIN_WIDTH +: BIN_WIDTH];
        neg_sel = SIGNED && raw_sel[BIN_WIDTH-1];
        mag_sel = neg_sel ? (~raw_sel + BIN_WIDTH'(1)) : raw_sel;
    end

    logic [BCD_W-1:0] bcd;
    logic             bcd_carry;

    dd_shift_core #(
        .BIN_WIDTH  (BIN_WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .load_i  (state_q == ST_LOAD),
        .step_i  (state_q == ST_SHIFT),
        .mag_i   (mag_sel),
        .bcd_o   (bcd),
        .carry_o (bcd_carry)
    );

    // Digit formatting for the channel being stored. Blanking walks down
    // from the top digit and stops at the first nonzero digit; digit 0 is
    // always printed, and a saturated value is never blanked.
    logic             fmt_ovf;
    logic             leading;
    logic [CH_W-1:0]  fmt_ascii;
    logic [3:0]       digit;

    always_comb begin
        fmt_ovf   = (bcd[BCD_W-1 -: 4] != 4'd0) || bcd_carry;
        leading   = BLANK_LZ && !fmt_ovf;
        fmt_ascii = '0;
        digit     = '0;
        for (int d = BCD_DIGITS - 1; d >= 0; d--) begin
            digit = bcd[d*4 +: 4];
            if (fmt_ovf) begin
                fmt_ascii[d*8 +: 8] = ASCII_NINE;
            end else if (leading && digit == 4'd0 && d != 0) begin
                fmt_ascii[d*8 +: 8] = ASCII_SPACE;
            end else begin
                fmt_ascii[d*8 +: 8] = ASCII_ZERO + {4'd0, digit};
                leading = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_STORE;
            ST_STORE: state_d = (ch_idx_q == LAST_CH) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Datapath: snapshot, iteration counters, shadow and committed results.
    // NOTE: snapshot and shadow arrays are reset explicitly so a reset gives a
    // fully known state; they are small registers, not RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_idx_q       <= '0;
            cnt_q          <= '0;
            snap_q         <= '0;
            shadow_ascii_q <= ASCII_INIT;
            shadow_neg_q   <= '0;
            shadow_ovf_q   <= '0;
            ascii_q        <= ASCII_INIT;
            neg_q          <= '0;
            ovf_q          <= '0;
            done_q         <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        snap_q   <= bin_flat;
                        ch_idx_q <= '0;
                    end
                end
                ST_LOAD:  cnt_q <= CNT_LOAD;
                ST_SHIFT: cnt_q <= cnt_q - CNT_W'(1);
                ST_STORE: begin
                    shadow_ascii_q[ch_idx_q*CH_W +: CH_W] <= fmt_ascii;
                    shadow_neg_q[ch_idx_q]                <= neg_sel;
                    shadow_ovf_q[ch_idx_q]                <= fmt_ovf;
                    if (ch_idx_q != LAST_CH) begin
                        ch_idx_q <= ch_idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    ascii_q <= shadow_ascii_q;
                    neg_q   <= shadow_neg_q;
                    ovf_q   <= shadow_ovf_q;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ascii_flat  = ascii_q;
    assign is_negative = neg_q;
    assign overflow    = ovf_q;
    assign done        = done_q;

endmodule

// File: tb/tb_multi_channel_bin2ascii.sv
// Self-checking bench: three instances (default, leading-zero blanking,
// three-digit) share the stimulus; expectations come from a decimal model.
module tb_multi_channel_bin2ascii;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         start;
    logic [47:0]  bin_flat;

    logic [127:0] ascii_a, ascii_b;
    logic [95:0]  ascii_c;
    logic [3:0]   neg_a, neg_b, neg_c, ovf_a, ovf_b, ovf_c;
    logic         busy_a, busy_b, busy_c, done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_channel_bin2ascii #(.NUM_CH(4), .BIN_WIDTH(12), .BCD_DIGITS(4),
                              .SIGNED(1'b1), .BLANK_LZ(1'b0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .bin_flat(bin_flat), .ascii_flat(ascii_a), .is_negative(neg_a),
        .overflow(ovf_a), .busy(busy_a), .done(done_a));

    multi_channel_bin2ascii #(.NUM_CH(4), .BIN_WIDTH(12), .BCD_DIGITS(4),
                              .SIGNED(1'b1), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .bin_flat(bin_flat), .ascii_flat(ascii_b), .is_negative(neg_b),
        .overflow(ovf_b), .busy(busy_b), .done(done_b));

    multi_channel_bin2ascii #(.NUM_CH(4), .BIN_WIDTH(12), .BCD_DIGITS(3),
                              .SIGNED(1'b1), .BLANK_LZ(1'b0)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .bin_flat(bin_flat), .ascii_flat(ascii_c), .is_negative(neg_c),
        .overflow(ovf_c), .busy(busy_c), .done(done_c));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int chan_val(input logic [11:0] raw);
        return raw[11] ? int'(raw) - 4096 : int'(raw);
    endfunction

    function automatic int chan_mag(input logic [11:0] raw);
        int v = chan_val(raw);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [127:0] model_ascii(input logic [47:0] bin, input int digits,
                                                 input bit blank);
        logic [127:0] r = '0;
        logic [7:0]   ch;
        for (int k = 0; k < 4; k++) begin
            int mag = chan_mag(bin[k*12 +: 12]);
            for (int d = 0; d < digits; d++) begin
                if (mag >= pow10(digits))           ch = "9";
                else if (blank && d > 0 && mag < pow10(d)) ch = " ";
                else                                ch = 8'("0" + (mag / pow10(d)) % 10);
                r[(k*digits + d)*8 +: 8] = ch;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] model_neg(input logic [47:0] bin);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = chan_val(bin[k*12 +: 12]) < 0;
        return r;
    endfunction

    function automatic logic [3:0] model_ovf(input logic [47:0] bin, input int digits);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = chan_mag(bin[k*12 +: 12]) >= pow10(digits);
        return r;
    endfunction

    function automatic logic [47:0] rand_bin();
        logic [47:0] r;
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k*12 +: 12] = 12'h800;
                1:       r[k*12 +: 12] = 12'h7FF;
                2:       r[k*12 +: 12] = 12'h000;
                3:       r[k*12 +: 12] = 12'hFFF;
                default: r[k*12 +: 12] = 12'($urandom());
            endcase
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(inout int lat);
        @(posedge clk);
        lat++;
        @(negedge clk);
    endtask

    task automatic wait_done(inout int lat);
        while (!done_a && lat < 300) step(lat);
    endtask

    // Starts a conversion from IDLE, scrambles bin_flat after acceptance,
    // returns the number of edges from acceptance to done.
    task automatic run_conv(input logic [47:0] bin, output int lat);
        bin_flat = bin;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        bin_flat = 48'({$urandom(), $urandom()});
        lat      = 0;
        wait_done(lat);
    endtask

    task automatic check_all(input string tag, input logic [47:0] bin);
        check({tag, "_ascii"},   ascii_a, model_ascii(bin, 4, 1'b0));
        check({tag, "_neg"},     neg_a,   model_neg(bin));
        check({tag, "_ovf"},     ovf_a,   model_ovf(bin, 4));
        check({tag, "_blank"},   ascii_b, model_ascii(bin, 4, 1'b1));
        check({tag, "_ascii3"},  ascii_c, model_ascii(bin, 3, 1'b0));
        check({tag, "_ovf3"},    ovf_c,   model_ovf(bin, 3));
    endtask

    initial begin
        int          lat;
        int          bad;
        int          last;
        int          npulse;
        logic [47:0] bin0;
        logic [127:0] held_ascii;

        reset    = 1'b0;
        enable   = 1'b1;
        start    = 1'b0;
        bin_flat = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_busy",  busy_a,  1'b0);
        check("rst_done",  done_a,  1'b0);
        check("rst_ascii", ascii_a, {16{8'h30}});
        check("rst_neg",   neg_a,   4'b0);
        check("rst_ovf",   ovf_a,   4'b0);
        reset = 1'b1;
        @(negedge clk);

        // Directed extremes: ch0..ch3 = 7FF, 800, 000, FFF.
        run_conv({12'hFFF, 12'h000, 12'h800, 12'h7FF}, lat);
        check("dir_latency", lat, 57);
        check("dir_ch0", ascii_a[31:0],   "2047");
        check("dir_ch1", ascii_a[63:32],  "2048");
        check("dir_ch2", ascii_a[95:64],  "0000");
        check("dir_ch3", ascii_a[127:96], "0001");
        check("dir_neg", neg_a, 4'b1010);
        check("dir_ovf", ovf_a, 4'b0000);
        check("dir_blank_ch3", ascii_b[127:96], "   1");
        check("dir_blank_ch2", ascii_b[95:64],  "   0");
        check("dir_blank_ch0", ascii_b[31:0],   "2047");
        check_all("dir", {12'hFFF, 12'h000, 12'h800, 12'h7FF});
        @(negedge clk);
        check("done_one_cycle", done_a, 1'b0);

        // Three-digit saturation boundary: 1000 saturates, 999 does not.
        run_conv({24'h0, 12'h3E7, 12'h3E8}, lat);
        check("ovf3_ch0", ascii_c[23:0],  "999");
        check("ovf3_ch1", ascii_c[47:24], "999");
        check("ovf3_flag0", ovf_c[0], 1'b1);
        check("ovf3_flag1", ovf_c[1], 1'b0);
        check_all("ovf3", {24'h0, 12'h3E7, 12'h3E8});

        // Randomized conversions, input scrambled after acceptance.
        for (int t = 0; t < 20; t++) begin
            bin0 = rand_bin();
            run_conv(bin0, lat);
            check($sformatf("rnd%0d_lat", t), lat, 57);
            check_all($sformatf("rnd%0d", t), bin0);
        end

        // Enable stall mid-SHIFT, input change and start re-pulses while busy.
        bin0     = rand_bin();
        bin_flat = bin0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bad   = 0;
        repeat (20) step(lat);
        enable   = 1'b0;
        bin_flat = rand_bin();
        for (int j = 0; j < 10; j++) begin
            start = (j == 3);
            step(lat);
            if (done_a) bad++;
        end
        start  = 1'b0;
        enable = 1'b1;
        check("stall_no_done", bad, 0);
        start = 1'b1;
        step(lat);
        start = 1'b0;
        wait_done(lat);
        check("stall_latency", lat, 67);
        check_all("stall", bin0);
        bad = 0;
        for (int j = 0; j < 80; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy_a || done_a) bad++;
        end
        check("stall_no_retrigger", bad, 0);

        // Reset mid-conversion.
        bin_flat = rand_bin();
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        repeat (30) step(lat);
        reset = 1'b0;
        #1;
        check("midrst_busy",  busy_a,  1'b0);
        check("midrst_ascii", ascii_a, {16{8'h30}});
        check("midrst_neg",   neg_a,   4'b0);
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 3) reset = 1'b1;
            if (done_a || busy_a) bad++;
        end
        check("midrst_no_done", bad, 0);
        bin0 = rand_bin();
        run_conv(bin0, lat);
        check("postrst_lat", lat, 57);
        check_all("postrst", bin0);

        // start held high: periodic re-trigger, stable outputs between pulses.
        bin0     = {12'h123, 12'hE00, 12'h05A, 12'h999};
        bin_flat = bin0;
        start    = 1'b1;
        last     = 0;
        npulse   = 0;
        bad      = 0;
        held_ascii = ascii_a;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) begin
                if (last > 0) check($sformatf("held_period%0d", npulse), i - last, 58);
                last = i;
                npulse++;
                held_ascii = ascii_a;
            end else if (npulse > 0 && ascii_a !== held_ascii) begin
                bad++;
            end
        end
        start = 1'b0;
        check("held_pulses", npulse, 3);
        check("held_stable", bad, 0);
        check_all("held", bin0);
        lat = 0;
        while (busy_a && lat < 300) step(lat);
        check("held_idle", busy_a, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
